// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register with EX-stage operand forwarding and load-use
//   hazard detection for the RV32 pipelined core.
//
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     stall_i               hold every registered field
//     flush_i               load a bubble (branch/jump squash)
//     id_*                  decoded operands, addresses and control from ID
//     exmem_*, memwb_*      writeback candidates from later stages
//     data1_o, data2_o      ALU operands (forwarded, imm-muxed)
//     alu_ctrl_o            registered ALU op code
//     store_data_o          forwarded rs2 value for stores
//     rd_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
//                           registered destination and control
//     hazard_o              load-use hazard; upstream holds PC and IF/ID
module ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [RADDR-1:0] id_rs1_i,
    input  logic [RADDR-1:0] id_rs2_i,
    input  logic [RADDR-1:0] id_rd_i,
    input  logic [2:0]       id_alu_ctrl_i,
    input  logic             id_alu_src_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             id_mem_to_reg_i,
    input  logic             exmem_reg_write_i,
    input  logic [RADDR-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]  exmem_data_i,
    input  logic             memwb_reg_write_i,
    input  logic [RADDR-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]  memwb_data_i,
    output logic [XLEN-1:0]  data1_o,
    output logic [XLEN-1:0]  data2_o,
    output logic [2:0]       alu_ctrl_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [RADDR-1:0] rd_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             hazard_o
);

    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [2:0]       alu_ctrl;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
    } ex_regs_t;

    ex_regs_t q;
    ex_regs_t d;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_comb begin
        d.rs1_data   = id_rs1_data_i;
        d.rs2_data   = id_rs2_data_i;
        d.imm        = id_imm_i;
        d.rs1        = id_rs1_i;
        d.rs2        = id_rs2_i;
        d.rd         = id_rd_i;
        d.alu_ctrl   = id_alu_ctrl_i;
        d.alu_src    = id_alu_src_i;
        d.reg_write  = id_reg_write_i;
        d.mem_read   = id_mem_read_i;
        d.mem_write  = id_mem_write_i;
        d.mem_to_reg = id_mem_to_reg_i;
    end

    // Bubble clears the whole record, data fields included.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (!stall_i) begin
            if (flush_i || hazard_o) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

    // Youngest producer wins; x0 is never forwarded.
    function automatic logic [XLEN-1:0] forward(input logic [RADDR-1:0] addr,
                                                input logic [XLEN-1:0]  regval);
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == addr))
            return exmem_data_i;
        else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == addr))
            return memwb_data_i;
        else
            return regval;
    endfunction

    always_comb begin
        fwd_a = forward(q.rs1, q.rs1_data);
        fwd_b = forward(q.rs2, q.rs2_data);
    end

    // rs2 is compared even for I-type instructions (conservative).
    always_comb begin
        hazard_o = q.mem_read && (q.rd != '0) &&
                   ((q.rd == id_rs1_i) || (q.rd == id_rs2_i));
    end

    always_comb begin
        data1_o      = fwd_a;
        data2_o      = q.alu_src ? q.imm : fwd_b;
        store_data_o = fwd_b;
        alu_ctrl_o   = q.alu_ctrl;
        rd_o         = q.rd;
        reg_write_o  = q.reg_write;
        mem_read_o   = q.mem_read;
        mem_write_o  = q.mem_write;
        mem_to_reg_o = q.mem_to_reg;
    end

endmodule
